// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// datapath select codes and the packed control vector.
package control_unit_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEMADR   = 5'd3,
        S_MEMREAD  = 5'd4,
        S_MEMWB    = 5'd5,
        S_MEMWRITE = 5'd6,
        S_EXECUTER = 5'd7,
        S_EXECUTEI = 5'd8,
        S_ALUWB    = 5'd9,
        S_JAL      = 5'd10,
        S_BRANCH   = 5'd11,
        S_JALR     = 5'd12,
        S_JALR_PC  = 5'd13,
        S_AUIPC    = 5'd14,
        S_LUI      = 5'd15,
        S_TRAP     = 5'd16,
        S_HALT     = 5'd17
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       pc_source;
        logic       reg_write;
        logic       memory_read;
        logic       memory_write;
        logic       is_immediate;
        logic       pc_write_cond;
        logic       lord;
        logic       memory_to_reg;
        logic [1:0] aluop;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       instr_retired;
        logic       trap;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/cu_output_decode.sv
// Combinational state -> control vector decode; mem_ready here is already
// qualified by the wait-enable setting in the top.
module cu_output_decode
    import control_unit_pkg::*;
#(
    parameter bit FENCE_NOP = 1'b1
) (
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.memory_read = 1'b1;
                ctrl.alu_src_a   = SRCA_PC;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.aluop       = ALUOP_ADD;
                // IR/PC load only on the completing cycle so each updates once
                ctrl.ir_write    = mem_ready;
                ctrl.pc_write    = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a     = SRCA_OLDPC;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.instr_retired = FENCE_NOP && (opcode == OP_FENCE);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.memory_read = 1'b1;
                ctrl.lord        = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.memory_to_reg = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.memory_write  = 1'b1;
                ctrl.lord          = 1'b1;
                ctrl.instr_retired = mem_ready;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ctrl.alu_src_a    = SRCA_RS1;
                ctrl.alu_src_b    = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
                ctrl.aluop        = ALUOP_FUNCT;
                ctrl.is_immediate = (state == S_EXECUTEI);
            end
            S_ALUWB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRCA_RS1;
                ctrl.alu_src_b     = SRCB_RS2;
                ctrl.aluop         = ALUOP_BR;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 1'b1;
            end
            S_JALR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_JALR_PC: begin
                ctrl.alu_src_a    = SRCA_OLDPC;
                ctrl.alu_src_b    = SRCB_FOUR;
                ctrl.pc_write     = 1'b1;
                ctrl.pc_source    = 1'b1;
                ctrl.is_immediate = 1'b1;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRCA_ZERO;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_TRAP:  ctrl.trap   = 1'b1;
            S_HALT:  ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit_mc_hs.sv
// Multicycle RV32I control FSM with memory ready handshake, illegal-opcode
// trap/halt, FENCE-as-NOP and a retire pulse.
module control_unit_mc_hs
    import control_unit_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit TRAP_EN     = 1'b1,
    parameter bit FENCE_NOP   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] instruction_opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       pc_source,
    output logic       reg_write,
    output logic       memory_read,
    output logic       memory_write,
    output logic       is_immediate,
    output logic       pc_write_cond,
    output logic       lorD,
    output logic       memory_to_reg,
    output logic [1:0] aluop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       instr_retired,
    output logic       trap,
    output logic       halted
);

    state_t state, state_nxt;
    ctrl_t  ctrl;
    logic   mem_rdy;
    logic   bad_goes_trap;

    assign mem_rdy       = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign bad_goes_trap = TRAP_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        unique case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  state_nxt = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instruction_opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECUTER;
                    OP_ITYPE:          state_nxt = S_EXECUTEI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_AUIPC:          state_nxt = S_AUIPC;
                    OP_LUI:            state_nxt = S_LUI;
                    OP_FENCE:          state_nxt = (!FENCE_NOP && bad_goes_trap) ? S_TRAP : S_FETCH;
                    default:           state_nxt = bad_goes_trap ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (instruction_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL, S_JALR_PC, S_AUIPC, S_LUI:
                        state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JALR:     state_nxt = S_JALR_PC;
            S_TRAP:     state_nxt = S_HALT;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_FETCH;
        endcase
    end

    cu_output_decode #(
        .FENCE_NOP(FENCE_NOP)
    ) u_decode (
        .state    (state),
        .opcode   (instruction_opcode),
        .mem_ready(mem_rdy),
        .ctrl     (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign ir_write      = ctrl.ir_write;
    assign pc_source     = ctrl.pc_source;
    assign reg_write     = ctrl.reg_write;
    assign memory_read   = ctrl.memory_read;
    assign memory_write  = ctrl.memory_write;
    assign is_immediate  = ctrl.is_immediate;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign lorD          = ctrl.lord;
    assign memory_to_reg = ctrl.memory_to_reg;
    assign aluop         = ctrl.aluop;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign instr_retired = ctrl.instr_retired;
    assign trap          = ctrl.trap;
    assign halted        = ctrl.halted;

endmodule

// File: tb/tb_control_unit_mc_hs.sv
// Scoreboard bench: stimulus queues the expected control vector per cycle,
// a negedge monitor pops and compares against the selected DUT instance.
module tb_control_unit_mc_hs;

    // vector: {pcw irw pcs rw mr mw imm pwc lorD m2r, aluop, a, b, retired trap halted}
    localparam logic [18:0] V_ZERO       = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] V_FETCH_W    = {10'b0000100000, 2'b00, 2'b00, 2'b01, 3'b000};
    localparam logic [18:0] V_FETCH_R    = {10'b1100100000, 2'b00, 2'b00, 2'b01, 3'b000};
    localparam logic [18:0] V_DECODE     = {10'b0000000000, 2'b00, 2'b10, 2'b10, 3'b000};
    localparam logic [18:0] V_DEC_FENCE  = {10'b0000000000, 2'b00, 2'b10, 2'b10, 3'b100};
    localparam logic [18:0] V_MEMADR     = {10'b0000000000, 2'b00, 2'b01, 2'b10, 3'b000};
    localparam logic [18:0] V_MEMREAD    = {10'b0000100010, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] V_MEMWB      = {10'b0001000001, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] V_MEMWRITE   = {10'b0000010010, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] V_MEMWRITE_R = {10'b0000010010, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] V_EXR        = {10'b0000000000, 2'b10, 2'b01, 2'b00, 3'b000};
    localparam logic [18:0] V_EXI        = {10'b0000001000, 2'b10, 2'b01, 2'b10, 3'b000};
    localparam logic [18:0] V_ALUWB      = {10'b0001000000, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] V_BRANCH     = {10'b0010000100, 2'b01, 2'b01, 2'b00, 3'b100};
    localparam logic [18:0] V_JAL        = {10'b1010000000, 2'b00, 2'b10, 2'b01, 3'b000};
    localparam logic [18:0] V_JALR       = {10'b0000000000, 2'b00, 2'b01, 2'b10, 3'b000};
    localparam logic [18:0] V_JALR_PC    = {10'b1010001000, 2'b00, 2'b10, 2'b01, 3'b000};
    localparam logic [18:0] V_AUIPC      = {10'b0000000000, 2'b00, 2'b10, 2'b10, 3'b000};
    localparam logic [18:0] V_LUI        = {10'b0000000000, 2'b00, 2'b11, 2'b10, 3'b000};
    localparam logic [18:0] V_TRAP       = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] V_HALT       = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b001};

    localparam logic [6:0] O_LOAD  = 7'b0000011, O_STORE = 7'b0100011, O_R    = 7'b0110011;
    localparam logic [6:0] O_I     = 7'b0010011, O_JAL   = 7'b1101111, O_BR   = 7'b1100011;
    localparam logic [6:0] O_JALR  = 7'b1100111, O_AUIPC = 7'b0010111, O_LUI  = 7'b0110111;
    localparam logic [6:0] O_FENCE = 7'b0001111, O_SYS   = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] op_w, op_nw;
    logic rdy_w, rdy_nw;

    logic       pcw_w, irw_w, pcs_w, rw_w, mr_w, mw_w, imm_w, pwc_w, lord_w, m2r_w, ret_w, trap_w, halt_w;
    logic [1:0] aop_w, a_w, b_w;
    logic       pcw_n, irw_n, pcs_n, rw_n, mr_n, mw_n, imm_n, pwc_n, lord_n, m2r_n, ret_n, trap_n, halt_n;
    logic [1:0] aop_n, a_n, b_n;
    logic [18:0] vec_w, vec_n;

    logic [19:0] exp_q[$];
    string       name_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    control_unit_mc_hs #(.MEM_WAIT_EN(1'b1), .TRAP_EN(1'b1), .FENCE_NOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instruction_opcode(op_w), .mem_ready(rdy_w),
        .pc_write(pcw_w), .ir_write(irw_w), .pc_source(pcs_w), .reg_write(rw_w),
        .memory_read(mr_w), .memory_write(mw_w), .is_immediate(imm_w), .pc_write_cond(pwc_w),
        .lorD(lord_w), .memory_to_reg(m2r_w), .aluop(aop_w), .alu_src_a(a_w), .alu_src_b(b_w),
        .instr_retired(ret_w), .trap(trap_w), .halted(halt_w)
    );

    control_unit_mc_hs #(.MEM_WAIT_EN(1'b0), .TRAP_EN(1'b1), .FENCE_NOP(1'b1)) dut_nw (
        .clk(clk), .rst_n(rst_n), .instruction_opcode(op_nw), .mem_ready(rdy_nw),
        .pc_write(pcw_n), .ir_write(irw_n), .pc_source(pcs_n), .reg_write(rw_n),
        .memory_read(mr_n), .memory_write(mw_n), .is_immediate(imm_n), .pc_write_cond(pwc_n),
        .lorD(lord_n), .memory_to_reg(m2r_n), .aluop(aop_n), .alu_src_a(a_n), .alu_src_b(b_n),
        .instr_retired(ret_n), .trap(trap_n), .halted(halt_n)
    );

    assign vec_w = {pcw_w, irw_w, pcs_w, rw_w, mr_w, mw_w, imm_w, pwc_w, lord_w, m2r_w,
                    aop_w, a_w, b_w, ret_w, trap_w, halt_w};
    assign vec_n = {pcw_n, irw_n, pcs_n, rw_n, mr_n, mw_n, imm_n, pwc_n, lord_n, m2r_n,
                    aop_n, a_n, b_n, ret_n, trap_n, halt_n};

    // Monitor: one queued expectation is consumed per cycle at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            logic [18:0] act;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = e[19] ? vec_n : vec_w;
            n_tests++;
            if (act !== e[18:0]) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, act, e[18:0]);
            end
        end
    end

    task automatic step(input logic sel, input logic [18:0] e, input string nm);
        exp_q.push_back({sel, e});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_w(input logic [6:0] op, input int unsigned waits);
        op_w = op;
        rdy_w = 1'b0;
        for (int unsigned i = 0; i < waits; i++) step(1'b0, V_FETCH_W, "fetch_wait");
        rdy_w = 1'b1;
        step(1'b0, V_FETCH_R, "fetch_ready");
        rdy_w = 1'b1;
    endtask

    task automatic reset_seq(input logic sel);
        rst_n = 1'b0;
        step(sel, V_ZERO, "in_reset");
        rst_n = 1'b1;
        step(sel, V_ZERO, "reset_release_c0");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_w = '0; op_nw = '0; rdy_w = 1'b0; rdy_nw = 1'b0;
        @(posedge clk);
        #1;
        reset_seq(1'b0);

        // LW: three stalls in FETCH and MEMREAD; mem_ready high in DECODE/MEMADR is ignored
        fetch_w(O_LOAD, 3);
        step(1'b0, V_DECODE, "lw_decode");
        step(1'b0, V_MEMADR, "lw_memadr");
        rdy_w = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, V_MEMREAD, "lw_memread_wait");
        rdy_w = 1'b1;
        step(1'b0, V_MEMREAD, "lw_memread_ready");
        step(1'b0, V_MEMWB, "lw_memwb");
        rdy_w = 1'b0;
        step(1'b0, V_FETCH_W, "lw_next_fetch");

        // SW: two stalls in MEMWRITE
        fetch_w(O_STORE, 0);
        step(1'b0, V_DECODE, "sw_decode");
        step(1'b0, V_MEMADR, "sw_memadr");
        rdy_w = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b0, V_MEMWRITE, "sw_memwrite_wait");
        rdy_w = 1'b1;
        step(1'b0, V_MEMWRITE_R, "sw_memwrite_ready");
        rdy_w = 1'b0;
        step(1'b0, V_FETCH_W, "sw_next_fetch");

        // R-type with handshake
        fetch_w(O_R, 1);
        step(1'b0, V_DECODE, "r_decode");
        step(1'b0, V_EXR, "r_execute");
        step(1'b0, V_ALUWB, "r_aluwb");

        // Reset during a stalled store
        fetch_w(O_STORE, 0);
        step(1'b0, V_DECODE, "abort_decode");
        step(1'b0, V_MEMADR, "abort_memadr");
        rdy_w = 1'b0;
        step(1'b0, V_MEMWRITE, "abort_memwrite");
        rst_n = 1'b0;
        step(1'b0, V_ZERO, "abort_reset_now");
        step(1'b0, V_ZERO, "abort_reset_held");
        rst_n = 1'b1;
        step(1'b0, V_ZERO, "abort_reset_state");
        step(1'b0, V_FETCH_W, "abort_fetch");

        // Illegal opcode -> TRAP -> HALT, mem_ready toggling has no effect
        fetch_w(O_SYS, 0);
        step(1'b0, V_DECODE, "trap_decode");
        step(1'b0, V_TRAP, "trap_pulse");
        for (int i = 0; i < 12; i++) begin
            rdy_w = i[0];
            step(1'b0, V_HALT, "halt_hold");
        end
        rdy_w = 1'b0;
        reset_seq(1'b0);
        step(1'b0, V_FETCH_W, "post_halt_fetch");

        // Fixed-latency instance: mem_ready held low and ignored
        reset_seq(1'b1);
        op_nw = O_R;     step(1'b1, V_FETCH_R, "nw_r_fetch");   step(1'b1, V_DECODE, "nw_r_decode");
                         step(1'b1, V_EXR, "nw_r_exec");        step(1'b1, V_ALUWB, "nw_r_aluwb");
        op_nw = O_I;     step(1'b1, V_FETCH_R, "nw_i_fetch");   step(1'b1, V_DECODE, "nw_i_decode");
                         step(1'b1, V_EXI, "nw_i_exec");        step(1'b1, V_ALUWB, "nw_i_aluwb");
        op_nw = O_JAL;   step(1'b1, V_FETCH_R, "nw_jal_fetch"); step(1'b1, V_DECODE, "nw_jal_decode");
                         step(1'b1, V_JAL, "nw_jal");           step(1'b1, V_ALUWB, "nw_jal_aluwb");
        op_nw = O_JALR;  step(1'b1, V_FETCH_R, "nw_jalr_fetch"); step(1'b1, V_DECODE, "nw_jalr_decode");
                         step(1'b1, V_JALR, "nw_jalr");         step(1'b1, V_JALR_PC, "nw_jalr_pc");
                         step(1'b1, V_ALUWB, "nw_jalr_aluwb");
        op_nw = O_BR;    step(1'b1, V_FETCH_R, "nw_br_fetch");  step(1'b1, V_DECODE, "nw_br_decode");
                         step(1'b1, V_BRANCH, "nw_branch");
        op_nw = O_AUIPC; step(1'b1, V_FETCH_R, "nw_auipc_fetch"); step(1'b1, V_DECODE, "nw_auipc_decode");
                         step(1'b1, V_AUIPC, "nw_auipc");       step(1'b1, V_ALUWB, "nw_auipc_aluwb");
        op_nw = O_LUI;   step(1'b1, V_FETCH_R, "nw_lui_fetch"); step(1'b1, V_DECODE, "nw_lui_decode");
                         step(1'b1, V_LUI, "nw_lui");           step(1'b1, V_ALUWB, "nw_lui_aluwb");
        op_nw = O_FENCE; step(1'b1, V_FETCH_R, "nw_fence_fetch"); step(1'b1, V_DEC_FENCE, "nw_fence_decode");
        op_nw = O_LOAD;  step(1'b1, V_FETCH_R, "nw_lw_fetch");  step(1'b1, V_DECODE, "nw_lw_decode");
                         step(1'b1, V_MEMADR, "nw_lw_memadr");  step(1'b1, V_MEMREAD, "nw_lw_memread");
                         step(1'b1, V_MEMWB, "nw_lw_memwb");
        op_nw = O_STORE; step(1'b1, V_FETCH_R, "nw_sw_fetch");  step(1'b1, V_DECODE, "nw_sw_decode");
                         step(1'b1, V_MEMADR, "nw_sw_memadr");  step(1'b1, V_MEMWRITE_R, "nw_sw_memwrite");
        op_nw = O_R;     step(1'b1, V_FETCH_R, "nw_final_fetch");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
